// File: rtl/aes_req_scheduler_if.sv
// aes_req_scheduler_if: requester, core and response signals of the AES request scheduler.
// master = environment (requesters, AES core, consumer); slave = scheduler.
interface aes_req_scheduler_if;
   logic         req0_valid, req0_ready, req1_valid, req1_ready;
   logic [127:0] req0_data, req0_key, req1_data, req1_key;
   logic         core_en, core_data_out_valid;
   logic [127:0] core_data_in, core_key_in, core_data_out;
   logic         resp_valid, resp_ready, resp_id, resp_err, busy;
   logic [127:0] resp_data;
   modport master (
      output req0_valid, req0_data, req0_key, req1_valid, req1_data, req1_key,
      output core_data_out, core_data_out_valid, resp_ready,
      input  req0_ready, req1_ready, core_en, core_data_in, core_key_in,
      input  resp_valid, resp_id, resp_data, resp_err, busy
   );
   modport slave (
      input  req0_valid, req0_data, req0_key, req1_valid, req1_data, req1_key,
      input  core_data_out, core_data_out_valid, resp_ready,
      output req0_ready, req1_ready, core_en, core_data_in, core_key_in,
      output resp_valid, resp_id, resp_data, resp_err, busy
   );
endinterface

// File: rtl/aes_req_scheduler.sv
// aes_req_scheduler: round-robin arbiter feeding one AES core from two requesters.
// Optional RUN timeout abort with macro AES_SCHED_TIMEOUT_EN.
module aes_req_scheduler #(
   parameter int TIMEOUT_CYC = 64
) (
   input logic               AES_clk,
   input logic               AES_rst,
   aes_req_scheduler_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;
   state_t       r_state, w_next;
   logic         r_ptr, r_id, r_err;
   logic [127:0] r_din, r_kin, r_dout;
   logic         w_idle, w_any, w_g1, w_done, w_tmo;

`ifdef AES_SCHED_TIMEOUT_EN
   logic [31:0] r_cnt;
   assign w_tmo = r_cnt == 32'(TIMEOUT_CYC - 1);
   always_ff @(posedge AES_clk)
      if (AES_rst) r_cnt <= '0;
      else r_cnt <= (r_state == RUN) ? r_cnt + 32'd1 : '0;
`else
   assign w_tmo = 1'b0;
`endif

   assign w_idle = (r_state == IDLE) & ~AES_rst;
   assign w_any  = bus.req0_valid | bus.req1_valid;
   // requester 1 wins when it is alone or holds the priority pointer
   assign w_g1   = bus.req1_valid & (~bus.req0_valid | r_ptr);
   assign w_done = bus.core_data_out_valid | w_tmo;

   always_comb begin
      w_next = r_state;
      w_next = (r_state == IDLE && w_any)          ? RUN  :
               (r_state == RUN  && w_done)         ? RESP :
               (r_state == RESP && bus.resp_ready) ? IDLE : r_state;
   end

   always_ff @(posedge AES_clk)
      if (AES_rst) begin
         r_state <= IDLE;
         r_ptr   <= 1'b0;
         r_id    <= 1'b0;
         r_err   <= 1'b0;
         r_din   <= '0;
         r_kin   <= '0;
         r_dout  <= '0;
      end else begin
         r_state <= w_next;
         if (w_idle && w_any) begin
            r_din <= w_g1 ? bus.req1_data : bus.req0_data;
            r_kin <= w_g1 ? bus.req1_key  : bus.req0_key;
            r_id  <= w_g1;
         end
         // a valid result wins over a simultaneous timeout
         if (r_state == RUN && w_done) begin
            r_dout <= bus.core_data_out_valid ? bus.core_data_out : '0;
            r_err  <= ~bus.core_data_out_valid;
         end
         if (r_state == RESP && bus.resp_ready) r_ptr <= ~r_id;
      end

   assign bus.req0_ready   = w_idle & bus.req0_valid & ~w_g1;
   assign bus.req1_ready   = w_idle & w_g1;
   assign bus.core_en      = r_state == RUN;
   assign bus.core_data_in = r_din;
   assign bus.core_key_in  = r_kin;
   assign bus.resp_valid   = r_state == RESP;
   assign bus.resp_id      = r_id;
   assign bus.resp_data    = r_dout;
   assign bus.resp_err     = r_err;
   assign bus.busy         = r_state != IDLE;
endmodule

// File: tb/tb_aes_req_scheduler.sv
// tb_aes_req_scheduler: directed tests of the AES request scheduler.
// A behavioural core model returns data^key core_lat cycles into RUN.
module tb_aes_req_scheduler;
   localparam logic [127:0] D0 = 128'h000000a9_00000000_00000000_00000000;
   localparam logic [127:0] K0 = 128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc;
   localparam logic [127:0] E0 = 128'haa2bdbe9_bff6a5e8_caa9ba3e_bc1e2acc;
   localparam logic [127:0] D1 = 128'h11111111_22222222_33333333_44444444;
   localparam logic [127:0] K1 = 128'h0f0f0f0f_0f0f0f0f_0f0f0f0f_0f0f0f0f;
   localparam logic [127:0] E1 = 128'h1e1e1e1e_2d2d2d2d_3c3c3c3c_4b4b4b4b;

   logic AES_clk = 1'b0;
   logic AES_rst = 1'b1;
   logic force_valid = 1'b0;
   int   core_lat = 1000;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   aes_req_scheduler_if bus();
   aes_req_scheduler #(.TIMEOUT_CYC(8)) dut (.AES_clk(AES_clk), .AES_rst(AES_rst), .bus(bus));

   always #5 AES_clk = ~AES_clk;
   always @(posedge AES_clk) cyc <= bus.core_en ? cyc + 1 : 0;
   assign bus.core_data_out_valid = (bus.core_en && cyc == core_lat) || force_valid;
   assign bus.core_data_out = force_valid ? 128'hdead_beef : bus.core_data_in ^ bus.core_key_in;

   task automatic idle_inputs;
      bus.req0_valid = 0; bus.req0_data = '0; bus.req0_key = '0;
      bus.req1_valid = 0; bus.req1_data = '0; bus.req1_key = '0;
      bus.resp_ready = 0;
   endtask

   task automatic do_reset;
      @(negedge AES_clk);
      AES_rst = 1; idle_inputs();
      @(negedge AES_clk);
      AES_rst = 0;
   endtask

   task automatic test_reset;
      @(negedge AES_clk);
      AES_rst = 1; idle_inputs(); bus.req0_valid = 1;
      @(negedge AES_clk); #1;
      total++;
      if ({bus.req0_ready, bus.req1_ready, bus.core_en, bus.resp_valid, bus.busy} !== 5'b0) begin
         bad++; $display("FAIL reset_ctrl got=%b want=00000", {bus.req0_ready, bus.req1_ready, bus.core_en, bus.resp_valid, bus.busy});
      end
      total++;
      if ({bus.resp_id, bus.resp_err} !== 2'b0 || bus.resp_data !== '0 || bus.core_data_in !== '0 || bus.core_key_in !== '0) begin
         bad++; $display("FAIL reset_data got id=%b err=%b data=%h din=%h kin=%h want all 0", bus.resp_id, bus.resp_err, bus.resp_data, bus.core_data_in, bus.core_key_in);
      end
      AES_rst = 0; bus.req0_valid = 0;
   endtask

   task automatic test_single;
      int n;
      core_lat = 3;
      @(negedge AES_clk);
      bus.req0_valid = 1; bus.req0_data = D0; bus.req0_key = K0; #1;
      total++;
      if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
         bad++; $display("FAIL single_grant got r0r1=%b want=10", {bus.req0_ready, bus.req1_ready});
      end
      @(negedge AES_clk); bus.req0_valid = 0; #1;
      total++;
      if (bus.req0_ready !== 0 || bus.core_en !== 1 || bus.core_data_in !== D0 || bus.core_key_in !== K0) begin
         bad++; $display("FAIL single_run got r0=%b en=%b din=%h kin=%h want 0 1 %h %h", bus.req0_ready, bus.core_en, bus.core_data_in, bus.core_key_in, D0, K0);
      end
      n = 1;
      while (bus.resp_valid !== 1 && n < 20) begin
         total++;
         if (bus.core_en !== 1) begin bad++; $display("FAIL single_core_en cycle=%0d got=%b want=1", n, bus.core_en); end
         @(negedge AES_clk); #1; n++;
      end
      total++;
      if (n != 5) begin bad++; $display("FAIL single_latency got=%0d want=5", n); end
      total++;
      if (bus.core_en !== 0 || bus.resp_id !== 0 || bus.resp_data !== E0 || bus.resp_err !== 0 || bus.busy !== 1) begin
         bad++; $display("FAIL single_resp got en=%b id=%b data=%h err=%b busy=%b want 0 0 %h 0 1", bus.core_en, bus.resp_id, bus.resp_data, bus.resp_err, bus.busy, E0);
      end
      bus.resp_ready = 1;
      @(negedge AES_clk); bus.resp_ready = 0; #1;
      total++;
      if (bus.resp_valid !== 0 || bus.busy !== 0) begin
         bad++; $display("FAIL single_idle got valid=%b busy=%b want 0 0", bus.resp_valid, bus.busy);
      end
   endtask

   task automatic test_alternate;
      int n;
      logic exp_id;
      do_reset();
      core_lat = 1;
      bus.req0_valid = 1; bus.req0_data = D0; bus.req0_key = K0;
      bus.req1_valid = 1; bus.req1_data = D1; bus.req1_key = K1;
      bus.resp_ready = 1;
      for (int g = 0; g < 4; g++) begin
         exp_id = g[0];
         n = 0; #1;
         while (!(bus.req0_ready || bus.req1_ready) && n < 20) begin @(negedge AES_clk); #1; n++; end
         total++;
         if ({bus.req1_ready, bus.req0_ready} !== (exp_id ? 2'b10 : 2'b01)) begin
            bad++; $display("FAIL alt_grant%0d got r1r0=%b want=%b", g, {bus.req1_ready, bus.req0_ready}, exp_id ? 2'b10 : 2'b01);
         end
         n = 0;
         do begin
            @(negedge AES_clk); #1; n++;
            total++;
            if (bus.req0_ready || bus.req1_ready) begin
               bad++; $display("FAIL alt_ready_busy%0d got r0=%b r1=%b want 0 0", g, bus.req0_ready, bus.req1_ready);
            end
         end while (!bus.resp_valid && n < 20);
         total++;
         if (bus.resp_id !== exp_id || bus.resp_data !== (exp_id ? E1 : E0)) begin
            bad++; $display("FAIL alt_resp%0d got id=%b data=%h want %b %h", g, bus.resp_id, bus.resp_data, exp_id, exp_id ? E1 : E0);
         end
         @(negedge AES_clk);
      end
      idle_inputs();
   endtask

   task automatic test_stall;
      int n;
      do_reset();
      core_lat = 2;
      bus.req1_valid = 1; bus.req1_data = D1; bus.req1_key = K1; #1;
      total++;
      if ({bus.req1_ready, bus.req0_ready} !== 2'b10) begin
         bad++; $display("FAIL stall_grant got r1r0=%b want=10", {bus.req1_ready, bus.req0_ready});
      end
      @(negedge AES_clk);
      bus.req1_valid = 0; bus.req0_valid = 1; bus.req0_data = D0; bus.req0_key = K0;
      n = 0; #1;
      while (!bus.resp_valid && n < 20) begin @(negedge AES_clk); #1; n++; end
      for (int i = 0; i < 10; i++) begin
         force_valid = (i == 3);
         #1;
         total++;
         if (bus.resp_valid !== 1 || bus.resp_data !== E1 || bus.resp_id !== 1 || bus.req0_ready !== 0 || bus.req1_ready !== 0 || bus.core_en !== 0) begin
            bad++; $display("FAIL stall_hold%0d got v=%b data=%h id=%b r0=%b r1=%b en=%b want 1 %h 1 0 0 0", i, bus.resp_valid, bus.resp_data, bus.resp_id, bus.req0_ready, bus.req1_ready, bus.core_en, E1);
         end
         @(negedge AES_clk);
      end
      force_valid = 0;
      bus.resp_ready = 1; #1;
      total++;
      if (bus.resp_valid !== 1 || bus.req0_ready !== 0) begin
         bad++; $display("FAIL stall_release got v=%b r0=%b want 1 0", bus.resp_valid, bus.req0_ready);
      end
      @(negedge AES_clk); bus.resp_ready = 0; #1;
      total++;
      if (bus.busy !== 0 || bus.req0_ready !== 1) begin
         bad++; $display("FAIL stall_next got busy=%b r0=%b want 0 1", bus.busy, bus.req0_ready);
      end
      @(negedge AES_clk); idle_inputs();
   endtask

   task automatic test_mid_reset;
      int n;
      do_reset();
      force_valid = 1;
      @(negedge AES_clk); force_valid = 0; #1;
      total++;
      if (bus.busy !== 0 || bus.resp_valid !== 0) begin
         bad++; $display("FAIL idle_ignore got busy=%b v=%b want 0 0", bus.busy, bus.resp_valid);
      end
      core_lat = 0;
      bus.req0_valid = 1; bus.req0_data = D0; bus.req0_key = K0; bus.resp_ready = 1;
      @(negedge AES_clk); bus.req0_valid = 0;
      n = 0; #1;
      while (!bus.resp_valid && n < 20) begin @(negedge AES_clk); #1; n++; end
      @(negedge AES_clk);
      core_lat = 1000; bus.resp_ready = 0; bus.req0_valid = 1;
      @(negedge AES_clk); bus.req0_valid = 0;
      @(negedge AES_clk); #1;
      total++;
      if (bus.core_en !== 1) begin bad++; $display("FAIL mid_run got en=%b want 1", bus.core_en); end
      AES_rst = 1;
      @(negedge AES_clk); AES_rst = 0; #1;
      total++;
      if ({bus.req0_ready, bus.req1_ready, bus.core_en, bus.resp_valid, bus.busy, bus.resp_id, bus.resp_err} !== 7'b0 || bus.resp_data !== '0 || bus.core_data_in !== '0 || bus.core_key_in !== '0) begin
         bad++; $display("FAIL mid_reset got ctl=%b data=%h din=%h want 0", {bus.req0_ready, bus.req1_ready, bus.core_en, bus.resp_valid, bus.busy, bus.resp_id, bus.resp_err}, bus.resp_data, bus.core_data_in);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge AES_clk); #1;
         total++;
         if (bus.resp_valid !== 0 || bus.busy !== 0) begin
            bad++; $display("FAIL mid_dropped%0d got v=%b busy=%b want 0 0", i, bus.resp_valid, bus.busy);
         end
      end
      bus.req0_valid = 1; bus.req1_valid = 1; #1;
      total++;
      if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin
         bad++; $display("FAIL mid_ptr got r1r0=%b want=01", {bus.req1_ready, bus.req0_ready});
      end
      @(negedge AES_clk); idle_inputs();
   endtask

   task automatic run_one(input int lat, input int exp_n, input logic exp_err, input logic [127:0] exp_data, input string nm);
      int n;
      do_reset();
      core_lat = lat;
      bus.req0_valid = 1; bus.req0_data = D0; bus.req0_key = K0;
      @(negedge AES_clk); bus.req0_valid = 0;
      n = 1; #1;
      while (!bus.resp_valid && n < 60) begin @(negedge AES_clk); #1; n++; end
      total++;
      if (n != exp_n || bus.resp_err !== exp_err || bus.resp_data !== exp_data) begin
         bad++; $display("FAIL %s got n=%0d err=%b data=%h want %0d %b %h", nm, n, bus.resp_err, bus.resp_data, exp_n, exp_err, exp_data);
      end
      bus.resp_ready = 1;
      @(negedge AES_clk); idle_inputs();
   endtask

   task automatic test_timeout;
`ifdef AES_SCHED_TIMEOUT_EN
      run_one(100, 9, 1'b1, '0, "timeout_abort");
      run_one(7, 9, 1'b0, E0, "timeout_valid_wins");
      run_one(6, 8, 1'b0, E0, "timeout_before");
`else
      run_one(20, 22, 1'b0, E0, "no_timeout_long");
`endif
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_single();
      test_alternate();
      test_stall();
      test_mid_reset();
      test_timeout();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
